// File: rtl/dac_seq_pkg.sv
// Shared types and DAC_DATA word layout for the AD5675 update sequencer.
// The word is {addr[1:0], cmd[3:0], ch[3:0], data[15:0]} = 26 bits.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [3:0] CMD_WRUPD = 4'h3;
  localparam logic [3:0] CMD_NOP   = 4'h0;

  localparam int DD_W        = 26;
  localparam int DD_ADDR_LSB = 24;
  localparam int DD_CMD_LSB  = 20;
  localparam int DD_CH_LSB   = 16;
  localparam int DD_DATA_LSB = 0;

  function automatic logic [DD_W-1:0] make_word(
    input logic [1:0]  addr,
    input logic [3:0]  cmd,
    input logic [2:0]  ch,
    input logic [15:0] data
  );
    logic [DD_W-1:0] w;
    w = {DD_W{1'b0}};
    w[DD_ADDR_LSB +: 2]  = addr;
    w[DD_CMD_LSB  +: 4]  = cmd;
    w[DD_CH_LSB   +: 4]  = {1'b0, ch};
    w[DD_DATA_LSB +: 16] = data;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin picker: first set request bit at or above ptr, wrapping 7->0.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] index
);

  logic [2:0] cand_s;

  assign valid = |req;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    index  = ptr;
    cand_s = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand_s = ptr + i[2:0];
      index  = req[cand_s] ? cand_s : index;
    end
  end

endmodule

// File: rtl/dac_update_sequencer.sv
// Setpoint bank plus dirty tracking that feeds one AD5675 write frame at a time
// to the I2C engine, holding DAC_DATA steady for the whole frame.
module dac_update_sequencer #(
  parameter logic [1:0] DEV_ADDR     = 2'b00,
  parameter logic [3:0] CMD_WRUPD    = 4'h3,
  parameter int         START_CYCLES = 2,
  parameter int         FRAME_CYCLES = 50
) (
  input  logic        CLOCK_01M,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_ch,
  input  logic [15:0] wr_data,
  input  logic        refresh_all,
  output logic        start,
  output logic [25:0] DAC_DATA,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pending
);
  import dac_seq_pkg::*;

  localparam int               CNT_W      = $clog2(START_CYCLES + FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             nop_r, nop_s;
  logic             launch_s;
  logic [7:0]       dirty_r, dirty_s, clr_mask_s, set_mask_s;
  logic [2:0]       ptr_r;
  logic [15:0]      setpt_r [8];
  logic             pick_valid_s;
  logic [2:0]       pick_idx_s;
  logic             start_r, busy_r, done_r;
  logic             start_s, busy_s, done_s;
  logic [25:0]      dac_data_r;

  rr_pick8 u_pick (
    .req   (dirty_r),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .index (pick_idx_s)
  );

  // Next-state, frame counter and launch decision.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    nop_s    = nop_r;
    launch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s  = ARM;
          cnt_s    = START_LAST;
          nop_s    = 1'b0;
          launch_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      ARM: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = WAIT;
          cnt_s   = FRAME_LAST;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // A same-cycle write or refresh overrides the launch clear, so the channel is resent.
  always_comb begin
    clr_mask_s = launch_s ? (8'b0000_0001 << pick_idx_s) : 8'h00;
    set_mask_s = (refresh_all ? 8'hFF : 8'h00) | (wr_en ? (8'b0000_0001 << wr_ch) : 8'h00);
    dirty_s    = (dirty_r & ~clr_mask_s) | set_mask_s;
    start_s    = (state_s == ARM);
    busy_s     = (state_s != IDLE);
    done_s     = (state_s == WAIT) && (cnt_s == CNT_ZERO) && !nop_s;
  end

  // Control state and registered outputs; reset parks in a NOP-absorbing WAIT.
  always_ff @(posedge CLOCK_01M) begin
    if (reset) begin
      state_r    <= WAIT;
      cnt_r      <= FRAME_LAST;
      nop_r      <= 1'b1;
      dirty_r    <= 8'h00;
      ptr_r      <= 3'd0;
      start_r    <= 1'b0;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      dac_data_r <= {DEV_ADDR, CMD_NOP, 20'h00000};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      nop_r   <= nop_s;
      dirty_r <= dirty_s;
      start_r <= start_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      if (launch_s) begin
        dac_data_r <= make_word(DEV_ADDR, CMD_WRUPD, pick_idx_s, setpt_r[pick_idx_s]);
        ptr_r      <= pick_idx_s + 3'd1;
      end
    end
  end

  // Setpoint bank.
  always_ff @(posedge CLOCK_01M) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        setpt_r[i] <= 16'h0000;
      end
    end else if (wr_en) begin
      setpt_r[wr_ch] <= wr_data;
    end
  end

  assign start    = start_r;
  assign DAC_DATA = dac_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pending  = dirty_r;

endmodule

// File: doc/dac_update_sequencer.md
# dac_update_sequencer

Upstream feeder for the AD5675 I2C write engine. Holds an 8-channel 16-bit setpoint bank written by the host logic and tracks which channels are dirty. For each dirty channel, in round-robin order, it drives one 26-bit DAC_DATA word plus a start pulse into the I2C engine, then holds the word stable until the 48-cycle frame has fully finished.

## Interface
Parameters:
- DEV_ADDR, 2'b00 — AD5675 A1/A0 pin strapping; DAC_DATA[25:24].
- CMD_WRUPD, 4'h3 — AD5675 "write and update DAC n" command; DAC_DATA[23:20].
- START_CYCLES, 2 — cycles `start` is held high per frame; legal range ≥2.
- FRAME_CYCLES, 50 — cycles waited after `start` falls; legal range ≥49.

Ports:
- CLOCK_01M  in  1  — sole clock, same clock as the I2C engine.
- reset  in  1  — reset; synchronous, active-high.
- wr_en  in  1  — setpoint write strobe.
- wr_ch  in  3  — channel index for the write.
- wr_data  in  16  — setpoint value.
- refresh_all  in  1  — one-cycle request to mark all 8 channels dirty.
- start  out  1  — to the I2C engine `start`.
- DAC_DATA  out  26  — to the I2C engine `DAC_DATA`.
- busy  out  1  — high while a frame is armed or in flight.
- done  out  1  — one-cycle pulse when a frame completes.
- pending  out  8  — current dirty bits, bit n = channel n.

## Operation
- Setpoint bank: `setpt[0..7]`, 16 bits each. On `wr_en`, `setpt[wr_ch] <= wr_data` and `dirty[wr_ch]` is set. Writes are accepted in every state.
- `refresh_all` ORs 8'hFF into `dirty`.
- FSM states and transitions:
  - IDLE: if `dirty != 0`, select channel `c` with the round-robin picker, starting at `ptr` and wrapping 7→0. On that same edge:
    - latch `DAC_DATA <= {DEV_ADDR, CMD_WRUPD, 1'b0, c[2:0], setpt[c]}`;
    - clear `dirty[c]`;
    - set `ptr <= c+1` (mod 8);
    - go to ARM.
  - ARM: `start=1` for exactly START_CYCLES cycles, then go to WAIT.
  - WAIT: `start=0` for FRAME_CYCLES cycles. `done=1` on the last WAIT cycle, then return to IDLE.
- `DAC_DATA` changes only on the IDLE→ARM edge. It is held through ARM, WAIT and IDLE until the next launch.
- Same-cycle set and clear on one channel: the set wins, so `dirty` stays 1 and the channel is reissued later with the new value.
- A write to the channel currently in flight does not alter `DAC_DATA`. It re-dirties the channel, which is then sent again.
- `busy` = (state is ARM or WAIT).
- Reset values:
  - `start=0`, `done=0`;
  - `DAC_DATA={DEV_ADDR,24'h0}` (command 0 = NOP);
  - all `setpt` and `dirty` = 0, `ptr=0`.
- After reset the FSM enters WAIT with a full FRAME_CYCLES count, so `busy=1` immediately. This absorbs the I2C engine's free-running power-up/post-reset frame, which then transmits a harmless NOP. This WAIT does not pulse `done`.
- Reset mid-frame: the same rule applies. `start` drops on the next cycle, and the interrupted channel is not re-queued.

## Timing
- Launch latency: dirty bit visible in IDLE → `start` high on the next cycle.
- Write while idle: `wr_en` at edge k sets `dirty` at k. IDLE sees it at k+1, and `start` is high from k+2.
- Per-word period: 1 + START_CYCLES + FRAME_CYCLES = 53 cycles at defaults. Eight channels take 424 cycles.
- FRAME_CYCLES ≥ 49 covers the engine's one-cycle GO register lag plus its 47-cycle count to the terminal state. `DAC_DATA` must not change before the engine's counter reaches 47.
- `pending` is registered `dirty`, with no extra latency.

## Structure
- Package `dac_seq_pkg` holds:
  - the state enum {IDLE, ARM, WAIT};
  - CMD_WRUPD, CMD_NOP = 4'h0;
  - the DAC_DATA field offsets (ADDR 25:24, CMD 23:20, CH 19:16, DATA 15:0).
- One sub-module, `rr_pick8`, is combinational. It takes 8-bit request and 3-bit ptr, and returns `valid` and a 3-bit index: the first set bit at or above ptr, wrapping.
- FSM, counter, bank and dirty logic stay in the top.

## Test plan
- Reset, then idle:
  - `start=0` and `DAC_DATA=26'h0000000` (DEV_ADDR=0) throughout;
  - `busy=1` for 50 cycles after reset release, then 0;
  - no `done` pulse.
- Single write (ch5, 0xABCD) when idle: `DAC_DATA=26'h035ABCD`, `start` high for 2 cycles, `done` 50 cycles after `start` falls, `pending` returns to 0.
- Writes to ch6, ch1 and ch3 in consecutive cycles, with `ptr=0` and the FSM in IDLE: the ch6 write is picked up first, because IDLE launches as soon as any dirty bit is visible; frames are then issued in order ch1, ch3 after it completes. Exactly 3 `done` pulses, spaced 53 cycles apart.
- Write ch2=0x1111, then during its WAIT write ch2=0x2222: `DAC_DATA` stays 0x0321111 until `done`, then the next frame carries 0x0322222.
- `refresh_all` with `ptr=4`: 8 frames in order ch4,5,6,7,0,1,2,3, each carrying the stored setpoints.
- Reset asserted in WAIT: the next cycle shows `start=0`, `pending=0` and `DAC_DATA` = NOP, and the 50-cycle post-reset WAIT follows.
